// File: rtl/pkt_vc_sched.sv
// Packet-atomic round-robin scheduler: one VC owns the NI-to-NoC flit port
// from head to tail so flits of different packets never interleave.
module pkt_vc_sched #(
  parameter int NumVC         = 2,
  parameter int FlitDataWidth = 32,
  parameter int PktWidth      = 8,
  parameter int VcWidth       = $clog2(NumVC)
) (
  input  logic                             clk_axi,
  input  logic                             arst_axi,
  input  logic [NumVC-1:0]                 vc_valid_i,
  input  logic [NumVC*FlitDataWidth-1:0]   vc_data_i,
  input  logic [NumVC*PktWidth-1:0]        vc_pkt_sz_i,
  output logic [NumVC-1:0]                 vc_ready_o,
  output logic                             out_valid_o,
  output logic [FlitDataWidth-1:0]         out_data_o,
  output logic [VcWidth-1:0]               out_vc_id_o,
  output logic [PktWidth-1:0]              out_pkt_sz_o,
  input  logic                             out_ready_i,
  output logic                             busy_o,
  output logic [NumVC-1:0]                 grant_o
);

  // Handshake: a flit moves on a cycle where out_valid_o && out_ready_i; the
  // granted requester sees the same cycle's out_ready_i on its vc_ready_o bit.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [VcWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VcWidth-1:0]   lock_vc_q, lock_vc_d;
  logic [PktWidth-1:0]  cnt_q, cnt_d;
  logic                 hold_q, hold_d;

  logic                 scan_found;
  logic [VcWidth-1:0]   scan_vc;
  logic                 gnt_any;
  logic [VcWidth-1:0]   gnt_vc;
  logic                 xfer;

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_vc_q <= '0;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_vc_q <= lock_vc_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  // Round-robin scan: first valid requester starting at rr_ptr.
  always_comb begin
    int                 idx;
    logic [VcWidth-1:0] idx_v;
    scan_found = 1'b0;
    scan_vc    = '0;
    for (int i = 0; i < NumVC; i++) begin
      idx   = (int'(rr_ptr_q) + i) % NumVC;
      idx_v = VcWidth'(idx);
      if (!scan_found && vc_valid_i[idx_v]) begin
        scan_found = 1'b1;
        scan_vc    = idx_v;
      end
    end
  end

  // A stalled head (hold) or a locked packet pins the grant to lock_vc.
  always_comb begin
    gnt_any = 1'b0;
    gnt_vc  = lock_vc_q;
    if (!arst_axi) begin
      if (state_q == LOCKED || hold_q) begin
        gnt_any = 1'b1;
      end else if (scan_found) begin
        gnt_any = 1'b1;
        gnt_vc  = scan_vc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_vc_d = lock_vc_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (gnt_any && xfer) begin
          hold_d   = 1'b0;
          rr_ptr_d = (gnt_vc == VcWidth'(NumVC - 1)) ? '0 : gnt_vc + 1'b1;
          if (out_pkt_sz_o != '0) begin
            cnt_d     = out_pkt_sz_o;
            lock_vc_d = gnt_vc;
            state_d   = LOCKED;
          end
        end else if (gnt_any && out_valid_o) begin
          hold_d    = 1'b1;
          lock_vc_d = gnt_vc;
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == PktWidth'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o      = '0;
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    out_pkt_sz_o = '0;
    out_vc_id_o  = '0;
    for (int n = 0; n < NumVC; n++) begin
      if (gnt_any && gnt_vc == VcWidth'(n)) begin
        grant_o[n]   = 1'b1;
        out_valid_o  = vc_valid_i[n];
        out_data_o   = vc_data_i[n*FlitDataWidth +: FlitDataWidth];
        out_pkt_sz_o = vc_pkt_sz_i[n*PktWidth +: PktWidth];
        out_vc_id_o  = VcWidth'(n);
      end
    end
    vc_ready_o = grant_o & {NumVC{out_ready_i}};
    busy_o     = (state_q == LOCKED);
    xfer       = out_valid_o && out_ready_i;
  end

endmodule

// File: tb/tb_pkt_vc_sched.sv
// Bench for pkt_vc_sched: directed scenarios plus random traffic, checked
// cycle by cycle against a packet-level ownership model and a flit scoreboard.
module tb_pkt_vc_sched;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int P  = 8;
  localparam int VW = $clog2(N);

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic           v_arr[N];
  logic [W-1:0]   d_arr[N];
  logic [P-1:0]   s_arr[N];
  logic           out_ready;

  logic [N-1:0]   vc_valid;
  logic [N*W-1:0] vc_data;
  logic [N*P-1:0] vc_sz;
  logic [N-1:0]   vc_ready, grant;
  logic           out_valid, busy;
  logic [W-1:0]   out_data;
  logic [VW-1:0]  out_vc_id;
  logic [P-1:0]   out_pkt_sz;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign vc_valid[g]       = v_arr[g];
    assign vc_data[g*W +: W] = d_arr[g];
    assign vc_sz[g*P +: P]   = s_arr[g];
  end

  pkt_vc_sched #(.NumVC(N), .FlitDataWidth(W), .PktWidth(P)) dut (
    .clk_axi      (clk),
    .arst_axi     (arst),
    .vc_valid_i   (vc_valid),
    .vc_data_i    (vc_data),
    .vc_pkt_sz_i  (vc_sz),
    .vc_ready_o   (vc_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_vc_id_o  (out_vc_id),
    .out_pkt_sz_o (out_pkt_sz),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .grant_o      (grant)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: which VC owns the port, flits left after the head, the
  // rotation pointer, and a head that was offered but not yet taken.
  int m_owner, m_left, m_rr, m_pend;
  logic [VW+W-1:0] exp_q[$];
  int xfer_ids[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_left  = 0;
    m_rr    = 0;
    m_pend  = -1;
    exp_q.delete();
  endfunction

  function automatic int exp_grant();
    if (m_owner >= 0) return m_owner;
    if (m_pend >= 0) return m_pend;
    for (int k = 0; k < N; k++) begin
      if (v_arr[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    int            g;
    logic          pred;
    logic [N-1:0]  eg;
    logic [VW+W-1:0] e;
    for (int n = 0; n < N; n++) d_arr[n] = $urandom;
    @(negedge clk);
    g    = arst ? -1 : exp_grant();
    eg   = '0;
    if (g >= 0) eg[g] = 1'b1;
    pred = (g >= 0) && v_arr[g] && out_ready;
    check("grant",      grant,      eg);
    check("out_valid",  out_valid,  (g >= 0) && v_arr[g]);
    check("out_data",   out_data,   (g >= 0) ? d_arr[g] : '0);
    check("out_vc_id",  out_vc_id,  (g >= 0) ? VW'(g) : '0);
    check("out_pkt_sz", out_pkt_sz, (g >= 0) ? s_arr[g] : '0);
    check("busy",       busy,       !arst && m_owner >= 0);
    check("vc_ready",   vc_ready,   out_ready ? eg : '0);
    if (pred) exp_q.push_back({VW'(g), d_arr[g]});
    if (out_valid && out_ready) begin
      xfer_ids.push_back(int'(out_vc_id));
      if (exp_q.size() == 0) check("sb_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_xfer", {out_vc_id, out_data}, e);
      end
    end
    @(posedge clk);
    if (arst) model_reset();
    else if (m_owner >= 0) begin
      if (pred) begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
    end else if (g >= 0) begin
      if (pred) begin
        m_pend = -1;
        m_rr   = (g + 1) % N;
        if (s_arr[g] != 0) begin
          m_owner = g;
          m_left  = int'(s_arr[g]);
        end
      end else if (v_arr[g]) m_pend = g;
    end
    #1;
  endtask

  // Compare the VC ids of the transfers seen since the last clear against
  // a bit pattern (bit k is the id of the k-th transfer).
  task automatic check_ids(input string tag, input int n, input logic [15:0] pat);
    check({tag, "_count"}, xfer_ids.size(), n);
    for (int k = 0; k < n; k++)
      if (k < xfer_ids.size()) check({tag, "_id"}, xfer_ids[k], pat[k]);
    xfer_ids.delete();
  endtask

  task automatic set_in(input logic v0, input logic [P-1:0] s0,
                        input logic v1, input logic [P-1:0] s1, input logic rdy);
    v_arr[0] = v0; s_arr[0] = s0;
    v_arr[1] = v1; s_arr[1] = s1;
    out_ready = rdy;
  endtask

  initial begin
    int lead;
    model_reset();
    set_in(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    arst = 1'b0;
    tick();

    // Single-flit packet from VC0, then rr_ptr=1 gives VC1 priority.
    set_in(1'b1, 8'd0, 1'b0, 8'd0, 1'b1); tick();
    set_in(1'b0, 8'd0, 1'b0, 8'd0, 1'b1); tick();
    set_in(1'b1, 8'd0, 1'b1, 8'd0, 1'b1); tick();
    check_ids("single", 2, 16'b10);

    // Atomicity: four VC0 flits, then VC1's head.
    set_in(1'b1, 8'd3, 1'b1, 8'd0, 1'b1);
    repeat (5) tick();
    check_ids("atomic", 5, 16'b10000);

    // Rotation with both VCs sending single-flit packets.
    set_in(1'b1, 8'd0, 1'b1, 8'd0, 1'b1);
    repeat (6) tick();
    check_ids("rr", 6, 16'b101010);
    set_in(1'b0, 8'd0, 1'b0, 8'd0, 1'b1); tick();

    // Stalled head on VC1 is not displaced by VC0 arriving.
    set_in(1'b0, 8'd0, 1'b1, 8'd0, 1'b0); tick();
    set_in(1'b1, 8'd0, 1'b1, 8'd0, 1'b0); repeat (3) tick();
    out_ready = 1'b1; tick();
    check_ids("stall", 1, 16'b1);

    // Bubbles and backpressure inside a locked VC0 packet.
    set_in(1'b1, 8'd2, 1'b1, 8'd0, 1'b1); tick();
    v_arr[0] = 1'b0;
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    v_arr[0] = 1'b1;
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    v_arr[0] = 1'b0; tick();
    check_ids("bubble", 4, 16'b1000);
    set_in(1'b0, 8'd0, 1'b0, 8'd0, 1'b1); tick();

    // Asynchronous reset in the middle of a packet.
    set_in(1'b1, 8'd5, 1'b1, 8'd0, 1'b1); tick();
    check_ids("pre_rst", 1, 16'b0);
    arst = 1'b1;
    #1;
    check("rst_grant", grant, '0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", vc_ready, '0);
    check("rst_busy",  busy, 1'b0);
    check("rst_data",  out_data, '0);
    model_reset();
    tick();
    arst = 1'b0;
    s_arr[0] = 8'd0;
    repeat (2) tick();
    check_ids("post_rst", 2, 16'b10);

    // Largest packet: 256 flits, sizes scrambled after the head.
    set_in(1'b1, 8'd255, 1'b1, 8'd0, 1'b1);
    for (int c = 0; c < 1500 && xfer_ids.size() < 257; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (m_owner == 0) begin
        s_arr[0] = P'($urandom);
        v_arr[0] = ($urandom_range(0, 9) != 0);
      end else v_arr[0] = 1'b1;
      tick();
    end
    lead = 0;
    while (lead < xfer_ids.size() && xfer_ids[lead] == 0) lead++;
    check("max_run", lead, 256);
    check("max_follow", xfer_ids.size() >= 257, 1'b1);
    xfer_ids.delete();
    set_in(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (3) tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < N; n++) begin
        v_arr[n] = ($urandom_range(0, 9) < 7);
        s_arr[n] = P'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      arst = ($urandom_range(0, 299) == 0);
      tick();
    end
    arst = 1'b0;
    set_in(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    repeat (2) tick();
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_vc_sched.md
Name: pkt_vc_sched

Overview:
- Packet-atomic round-robin scheduler that shares the single NI-to-NoC flit port (packet processor input) among NumVC per-VC transmit requesters.
- Grants one VC per packet and holds the grant from head to tail, so flits of different packets never interleave on the local send path.
- Sits between the AXI slave per-VC write buffers and the packet processor; the clock/reset domain is the AXI domain.

Parameters:
- NumVC, 2: number of requesting virtual channels; minimum 2.
- FlitDataWidth, 32: flit payload width.
- PktWidth, 8: packet size field width; counts flits following the head.
- VcWidth, $clog2(NumVC): VC id width.

Ports:
- clk_axi  in  1  clock.
- arst_axi  in  1  asynchronous active-high reset.
- vc_valid_i  in  NumVC  per-VC flit valid.
- vc_data_i  in  NumVC*FlitDataWidth  per-VC flit data; VC n occupies slice n.
- vc_pkt_sz_i  in  NumVC*PktWidth  per-VC packet size, sampled on head acceptance.
- vc_ready_o  out  NumVC  per-VC accept.
- out_valid_o  out  1  flit valid to packet processor.
- out_data_o  out  FlitDataWidth  selected flit data.
- out_vc_id_o  out  VcWidth  selected VC id.
- out_pkt_sz_o  out  PktWidth  selected packet size.
- out_ready_i  in  1  packet processor ready.
- busy_o  out  1  high while a packet is locked.
- grant_o  out  NumVC  one-hot current grant; all zero when none.

Behaviour:
- Clock and reset: single clock clk_axi; arst_axi is asynchronous, active-high.
- Reset values: state IDLE, rr_ptr 0, cnt 0, hold 0, lock_vc 0. All outputs are 0 during and after reset until a request arrives.
- Transfer: a flit transfers when out_valid_o && out_ready_i. vc_ready_o[n] = out_ready_i && grant_o[n]; it is combinational, with zero added latency.
- Mux: out_data_o, out_pkt_sz_o and out_vc_id_o are taken from the granted VC. out_valid_o = vc_valid_i[granted]. When no VC is granted, out_data_o, out_pkt_sz_o and out_vc_id_o are 0.

State IDLE (waiting for a head):
- The winner is the first asserted vc_valid_i, scanning rr_ptr, rr_ptr+1, … modulo NumVC.
- If hold=1, the winner is lock_vc instead of the scan. This freezes the grant for a head that was offered but stalled; a higher-priority arrival must not change a stalled head.
- Head offered and not accepted: set hold=1 and lock_vc=winner.
- Head accepted: clear hold and set rr_ptr=(winner+1) mod NumVC.
  - If pkt_sz=0 (single-flit packet), stay in IDLE.
  - Otherwise set cnt=pkt_sz and lock_vc=winner, then go to LOCKED.
- busy_o=0.

State LOCKED:
- Only lock_vc is granted; grant_o is one-hot on lock_vc even while its valid is low.
- Each accepted flit decrements cnt. Accepting with cnt=1 returns to IDLE next cycle.
- busy_o=1.

Boundary conditions:
- Requester drops valid mid-packet: out_valid_o=0, the grant is kept and no other VC may be granted.
- out_ready_i low: all counters and pointers hold.
- Simultaneous requests from all VCs: strict rotation, one packet each.
- pkt_sz=2^PktWidth-1: a packet of 2^PktWidth flits with no overflow; cnt is PktWidth bits wide.
- vc_pkt_sz_i is ignored after head acceptance.
- Reset mid-packet: immediate return to IDLE with the grant cleared; the partial packet is abandoned.

Test Plan:
- Single VC: VC0 sends pkt_sz=0 with ready=1 → one transfer, out_vc_id_o=0, busy_o stays 0, rr_ptr becomes 1.
- Packet atomicity: VC0 has pkt_sz=3 (4 flits) and VC1 is valid throughout → 4 consecutive VC0 flits, then VC1's head on cycle 5, busy_o high for cycles 2-4.
- Round-robin: NumVC=2, both VCs continuously sending single-flit packets with ready=1 → grants alternate 0,1,0,1; grant_o is never 2'b11.
- Stalled head: VC1 is offered with ready=0, then VC0 asserts valid → grant_o stays 2'b10 until ready=1 accepts VC1's head.
- Bubble and backpressure: VC0 is locked with cnt=2, drops valid for 3 cycles, and ready toggles → no VC1 flit appears, cnt decrements only on transfers, IDLE follows the final flit.
- Reset mid-packet: arst_axi pulses while locked with cnt=5 → outputs 0 immediately, and the next grant follows rr_ptr=0.
